// File: rtl/branch_exec_unit_if.sv
// Op-issue and result handshake bundle for the branch execution unit.
// The slave modport is the unit; the master modport is the issuer/consumer.
interface branch_exec_unit_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [2:0]       in_func;
  logic [XLEN-1:0]  in_rs1;
  logic [XLEN-1:0]  in_rs2;
  logic [XLEN-1:0]  in_pc;
  logic [XLEN-1:0]  in_imm;
  logic             in_pred_taken;
  logic [XLEN-1:0]  in_pred_target;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [TAG_W-1:0] out_tag;
  logic             out_taken;
  logic [XLEN-1:0]  out_target;
  logic [XLEN-1:0]  out_next_pc;
  logic [XLEN-1:0]  out_link;
  logic             out_mispredict;

  modport slave (
    input  in_valid, in_op, in_func, in_rs1, in_rs2, in_pc, in_imm,
           in_pred_taken, in_pred_target, in_tag, out_ready,
    output in_ready, out_valid, out_tag, out_taken, out_target,
           out_next_pc, out_link, out_mispredict
  );

  modport master (
    output in_valid, in_op, in_func, in_rs1, in_rs2, in_pc, in_imm,
           in_pred_taken, in_pred_target, in_tag, out_ready,
    input  in_ready, out_valid, out_tag, out_taken, out_target,
           out_next_pc, out_link, out_mispredict
  );
endinterface

// File: rtl/branch_exec_unit.sv
// Two-stage branch/jump resolution unit: S1 latches operands, S2 latches the
// resolved outcome; saturating counters track retired and mispredicted ops.
module branch_exec_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  branch_exec_unit_if.slave    bus,
  output logic [CNT_W-1:0]     br_count,
  output logic [CNT_W-1:0]     mispred_count
);

  typedef enum logic [1:0] {
    OP_BR   = 2'd0,
    OP_JAL  = 2'd1,
    OP_JALR = 2'd2,
    OP_RSV  = 2'd3
  } op_e;

  // S1 operand latch
  logic             s1_valid_q;
  op_e              s1_op_q;
  logic [2:0]       s1_func_q;
  logic [XLEN-1:0]  s1_rs1_q, s1_rs2_q, s1_pc_q, s1_imm_q, s1_ptgt_q;
  logic             s1_ptaken_q;
  logic [TAG_W-1:0] s1_tag_q;

  // S2 result latch
  logic             s2_valid_q;
  logic [TAG_W-1:0] s2_tag_q;
  logic             s2_taken_q;
  logic [XLEN-1:0]  s2_target_q, s2_next_pc_q, s2_link_q;
  logic             s2_mis_q;

  logic [CNT_W-1:0] br_count_q, br_count_d;
  logic [CNT_W-1:0] mis_count_q, mis_count_d;

  logic             handshake_c, s1_adv_c, in_ready_c, accept_c, count_en_c;
  logic             br_cond_c, taken_c, mis_c;
  logic [XLEN-1:0]  sum_pc_c, sum_rs_c, link_c, target_c, next_pc_c;

  assign handshake_c = s2_valid_q && bus.out_ready;
  assign s1_adv_c    = s1_valid_q && (!s2_valid_q || handshake_c);
  assign in_ready_c  = !reset && !flush && (!s1_valid_q || s1_adv_c);
  assign accept_c    = bus.in_valid && in_ready_c;
  assign count_en_c  = handshake_c && !flush;

  // Resolve condition, target and prediction check from S1 operands
  always_comb begin
    sum_pc_c = s1_pc_q + s1_imm_q;
    sum_rs_c = s1_rs1_q + s1_imm_q;
    link_c   = s1_pc_q + XLEN'(4);
    br_cond_c = 1'b0;
    case (s1_func_q)
      3'b000:  br_cond_c = (s1_rs1_q == s1_rs2_q);
      3'b001:  br_cond_c = (s1_rs1_q != s1_rs2_q);
      3'b100:  br_cond_c = ($signed(s1_rs1_q) <  $signed(s1_rs2_q));
      3'b101:  br_cond_c = ($signed(s1_rs1_q) >= $signed(s1_rs2_q));
      3'b110:  br_cond_c = (s1_rs1_q <  s1_rs2_q);
      3'b111:  br_cond_c = (s1_rs1_q >= s1_rs2_q);
      default: br_cond_c = 1'b0;
    endcase
    taken_c  = 1'b0;
    target_c = sum_pc_c;
    case (s1_op_q)
      OP_BR:   taken_c = br_cond_c;
      OP_JAL:  taken_c = 1'b1;
      OP_JALR: begin
        taken_c  = 1'b1;
        target_c = {sum_rs_c[XLEN-1:1], 1'b0};
      end
      default: taken_c = 1'b0;
    endcase
    next_pc_c = taken_c ? target_c : link_c;
    mis_c     = (taken_c != s1_ptaken_q) || (taken_c && (target_c != s1_ptgt_q));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OP_BR;
      s1_func_q   <= 3'd0;
      s1_rs1_q    <= '0;
      s1_rs2_q    <= '0;
      s1_pc_q     <= '0;
      s1_imm_q    <= '0;
      s1_ptaken_q <= 1'b0;
      s1_ptgt_q   <= '0;
      s1_tag_q    <= '0;
    end else begin
      if (flush)         s1_valid_q <= 1'b0;
      else if (accept_c) s1_valid_q <= 1'b1;
      else if (s1_adv_c) s1_valid_q <= 1'b0;
      if (accept_c) begin
        s1_op_q     <= op_e'(bus.in_op);
        s1_func_q   <= bus.in_func;
        s1_rs1_q    <= bus.in_rs1;
        s1_rs2_q    <= bus.in_rs2;
        s1_pc_q     <= bus.in_pc;
        s1_imm_q    <= bus.in_imm;
        s1_ptaken_q <= bus.in_pred_taken;
        s1_ptgt_q   <= bus.in_pred_target;
        s1_tag_q    <= bus.in_tag;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s2_valid_q   <= 1'b0;
      s2_tag_q     <= '0;
      s2_taken_q   <= 1'b0;
      s2_target_q  <= '0;
      s2_next_pc_q <= '0;
      s2_link_q    <= '0;
      s2_mis_q     <= 1'b0;
    end else begin
      if (flush)            s2_valid_q <= 1'b0;
      else if (s1_adv_c)    s2_valid_q <= 1'b1;
      else if (handshake_c) s2_valid_q <= 1'b0;
      if (s1_adv_c && !flush) begin
        s2_tag_q     <= s1_tag_q;
        s2_taken_q   <= taken_c;
        s2_target_q  <= target_c;
        s2_next_pc_q <= next_pc_c;
        s2_link_q    <= link_c;
        s2_mis_q     <= mis_c;
      end
    end
  end

  // Saturating performance counters, bumped on retired handshakes only
  always_comb begin
    br_count_d  = br_count_q;
    mis_count_d = mis_count_q;
    if (count_en_c && (br_count_q != '1))
      br_count_d = br_count_q + CNT_W'(1);
    if (count_en_c && s2_mis_q && (mis_count_q != '1))
      mis_count_d = mis_count_q + CNT_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      br_count_q  <= '0;
      mis_count_q <= '0;
    end else begin
      br_count_q  <= br_count_d;
      mis_count_q <= mis_count_d;
    end
  end

  assign bus.in_ready       = in_ready_c;
  assign bus.out_valid      = s2_valid_q;
  assign bus.out_tag        = s2_tag_q;
  assign bus.out_taken      = s2_taken_q;
  assign bus.out_target     = s2_target_q;
  assign bus.out_next_pc    = s2_next_pc_q;
  assign bus.out_link       = s2_link_q;
  assign bus.out_mispredict = s2_mis_q;
  assign br_count           = br_count_q;
  assign mispred_count      = mis_count_q;

endmodule

// File: tb/tb_branch_exec_unit.sv
// Randomized scoreboard bench for branch_exec_unit, with directed latency,
// backpressure, flush, saturation and asynchronous-reset scenarios.
module tb_branch_exec_unit;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 5;
  localparam int unsigned CNT_W = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  logic [CNT_W-1:0] br_count, mispred_count;
  logic [1:0]       br2, mis2;

  branch_exec_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bif ();
  branch_exec_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bif2 ();

  branch_exec_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .CNT_W(CNT_W)) u_dut (
    .clock(clock), .reset(reset), .flush(flush), .bus(bif.slave),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  // Second copy with 2-bit counters, fed the same stimulus, for saturation
  branch_exec_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .CNT_W(2)) u_sat (
    .clock(clock), .reset(reset), .flush(flush), .bus(bif2.slave),
    .br_count(br2), .mispred_count(mis2)
  );

  assign bif2.in_valid       = bif.in_valid;
  assign bif2.in_op          = bif.in_op;
  assign bif2.in_func        = bif.in_func;
  assign bif2.in_rs1         = bif.in_rs1;
  assign bif2.in_rs2         = bif.in_rs2;
  assign bif2.in_pc          = bif.in_pc;
  assign bif2.in_imm         = bif.in_imm;
  assign bif2.in_pred_taken  = bif.in_pred_taken;
  assign bif2.in_pred_target = bif.in_pred_target;
  assign bif2.in_tag         = bif.in_tag;
  assign bif2.out_ready      = bif.out_ready;

  always #5 clock = ~clock;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             taken;
    logic [XLEN-1:0]  target;
    logic [XLEN-1:0]  next_pc;
    logic [XLEN-1:0]  link;
    logic             mis;
  } res_t;

  res_t exp_q[$];
  int   errors = 0, checks = 0;
  int   exp_br = 0, exp_mis = 0, accepted = 0;
  logic rnd_bp = 1'b0, rnd_fl = 1'b0;
  logic [TAG_W-1:0] next_tag = '0;

  // Architectural reference: what a branch/jump resolves to
  function automatic res_t model(input logic [1:0] op, input logic [2:0] func,
                                 input logic [XLEN-1:0] rs1, rs2, pc, imm,
                                 input logic pt, input logic [XLEN-1:0] ptgt,
                                 input logic [TAG_W-1:0] tag);
    res_t r;
    logic t;
    logic [XLEN-1:0] tgt;
    t = 1'b0;
    if (op == 2'd1 || op == 2'd2) t = 1'b1;
    else if (op == 2'd0) begin
      case (func)
        3'd0: t = (rs1 == rs2);
        3'd1: t = (rs1 != rs2);
        3'd4: t = ($signed(rs1) <  $signed(rs2));
        3'd5: t = ($signed(rs1) >= $signed(rs2));
        3'd6: t = (rs1 < rs2);
        3'd7: t = (rs1 >= rs2);
        default: t = 1'b0;
      endcase
    end
    if (op == 2'd2) tgt = (rs1 + imm) & ~XLEN'(1);
    else            tgt = pc + imm;
    r.tag     = tag;
    r.taken   = t;
    r.target  = tgt;
    r.link    = pc + XLEN'(4);
    r.next_pc = t ? tgt : r.link;
    r.mis     = (t != pt) || (t && (tgt != ptgt));
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Issue side of the scoreboard: record every accepted op
  always @(negedge clock) begin
    if (!reset && bif.in_valid && bif.in_ready) begin
      exp_q.push_back(model(bif.in_op, bif.in_func, bif.in_rs1, bif.in_rs2, bif.in_pc,
                            bif.in_imm, bif.in_pred_taken, bif.in_pred_target, bif.in_tag));
      accepted++;
    end
  end

  // Monitor: compare results, counters and backpressure stability
  res_t cur, prev, want;
  logic stall_prev = 1'b0;
  always @(negedge clock) begin
    cur = {bif.out_tag, bif.out_taken, bif.out_target, bif.out_next_pc,
           bif.out_link, bif.out_mispredict};
    if (reset) begin
      exp_q.delete();
      exp_br = 0;
      exp_mis = 0;
      stall_prev = 1'b0;
    end else begin
      chk("br_count", 64'(br_count), 64'(exp_br));
      chk("mispred_count", 64'(mispred_count), 64'(exp_mis));
      chk("sat_br_count", 64'(br2), 64'((exp_br > 3) ? 3 : exp_br));
      chk("sat_mispred_count", 64'(mis2), 64'((exp_mis > 3) ? 3 : exp_mis));
      if (stall_prev) begin
        checks++;
        if (!bif.out_valid || cur !== prev) begin
          errors++;
          $display("FAIL stall_stable: got v=%0b %h expected v=1 %h", bif.out_valid, cur, prev);
        end
      end
      if (flush) exp_q.delete();
      else if (bif.out_valid && bif.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got %h expected no output", cur);
        end else begin
          want = exp_q.pop_front();
          if (cur !== want) begin
            errors++;
            $display("FAIL result tag=%0d: got %h expected %h", want.tag, cur, want);
          end
          exp_br++;
          if (want.mis) exp_mis++;
        end
      end
      stall_prev = bif.out_valid && !bif.out_ready && !flush;
      prev = cur;
    end
  end

  // Random backpressure and flush injection
  always @(posedge clock) begin
    #1;
    if (rnd_bp) bif.out_ready = ($urandom_range(0, 3) != 0);
    if (rnd_fl) flush = ($urandom_range(0, 24) == 0);
  end

  task automatic sync();
    @(posedge clock);
    #1;
  endtask

  // Call at posedge+1; returns at posedge+1 of the cycle after acceptance
  task automatic send(input logic [1:0] op, input logic [2:0] func,
                      input logic [XLEN-1:0] rs1, rs2, pc, imm,
                      input logic pt, input logic [XLEN-1:0] ptgt);
    bit done;
    done = 0;
    bif.in_op = op; bif.in_func = func; bif.in_rs1 = rs1; bif.in_rs2 = rs2;
    bif.in_pc = pc; bif.in_imm = imm; bif.in_pred_taken = pt;
    bif.in_pred_target = ptgt; bif.in_tag = next_tag;
    next_tag = next_tag + TAG_W'(1);
    bif.in_valid = 1'b1;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clock);
      if (bif.in_ready) done = 1;
      @(posedge clock);
      #1;
    end
    bif.in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected acceptance");
    end
  endtask

  task automatic send_rand();
    logic [1:0] op; logic [2:0] func;
    logic [XLEN-1:0] rs1, rs2, pc, imm, ptgt;
    logic pt;
    res_t m;
    op   = 2'($urandom_range(0, 3));
    func = 3'($urandom_range(0, 7));
    rs1  = $urandom;
    case ($urandom_range(0, 3))
      0: rs2 = rs1;
      1: rs2 = rs1 + XLEN'(1);
      2: rs2 = ~rs1;
      default: rs2 = $urandom;
    endcase
    pc  = $urandom & ~XLEN'(3);
    imm = XLEN'($urandom_range(0, 4095)) - XLEN'(2048);
    pt  = 1'($urandom_range(0, 1));
    m   = model(op, func, rs1, rs2, pc, imm, pt, '0, '0);
    ptgt = ($urandom_range(0, 1) == 1) ? m.target : $urandom;
    send(op, func, rs1, rs2, pc, imm, pt, ptgt);
  endtask

  // Send one op on an idle pipe; return at the negedge where it is on the output
  task automatic directed(input string name, input logic [1:0] op, input logic [2:0] func,
                          input logic [XLEN-1:0] rs1, rs2, pc, imm,
                          input logic pt, input logic [XLEN-1:0] ptgt);
    send(op, func, rs1, rs2, pc, imm, pt, ptgt);
    @(negedge clock);
    chk({name, "_latency_n1"}, 64'(bif.out_valid), 64'd0);
    @(negedge clock);
    chk({name, "_latency_n2"}, 64'(bif.out_valid), 64'd1);
  endtask

  task automatic drain();
    bit empty;
    empty = 0;
    for (int i = 0; i < 1000 && !empty; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0) empty = 1;
    end
    checks++;
    if (!empty) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    @(negedge clock);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    bif.in_valid = 1'b0; bif.in_op = '0; bif.in_func = '0; bif.in_rs1 = '0;
    bif.in_rs2 = '0; bif.in_pc = '0; bif.in_imm = '0; bif.in_pred_taken = 1'b0;
    bif.in_pred_target = '0; bif.in_tag = '0; bif.out_ready = 1'b0;
    #1 reset = 1'b1;
    #2;
    chk("rst_out_valid", 64'(bif.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bif.in_ready), 64'd0);
    chk("rst_data", 64'({bif.out_tag, bif.out_taken, bif.out_mispredict}), 64'd0);
    chk("rst_target", 64'(bif.out_target | bif.out_next_pc | bif.out_link), 64'd0);
    chk("rst_counters", 64'({br_count, mispred_count}), 64'd0);
    @(posedge clock); @(posedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    chk("in_ready_after_reset", 64'(bif.in_ready), 64'd1);
    sync();

    bif.out_ready = 1'b1;
    directed("blt", 2'd0, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0);
    chk("blt_taken", 64'(bif.out_taken), 64'd1);
    chk("blt_target", 64'(bif.out_target), 64'h120);
    chk("blt_next_pc", 64'(bif.out_next_pc), 64'h120);
    chk("blt_mispredict", 64'(bif.out_mispredict), 64'd1);
    @(negedge clock);
    chk("blt_mispred_count", 64'(mispred_count), 64'd1);
    sync();

    directed("bltu", 2'd0, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0);
    chk("bltu_taken", 64'(bif.out_taken), 64'd0);
    chk("bltu_next_pc", 64'(bif.out_next_pc), 64'h104);
    chk("bltu_link", 64'(bif.out_link), 64'h104);
    chk("bltu_mispredict", 64'(bif.out_mispredict), 64'd0);
    sync();

    directed("jalr", 2'd2, 3'b000, 32'h1003, 32'h0, 32'h200, 32'h4, 1'b1, 32'h1006);
    chk("jalr_target", 64'(bif.out_target), 64'h1006);
    chk("jalr_taken", 64'(bif.out_taken), 64'd1);
    chk("jalr_mispredict", 64'(bif.out_mispredict), 64'd0);
    sync();
    directed("jalr_wrap", 2'd2, 3'b000, 32'h1003, 32'h0, 32'hFFFF_FFFC, 32'h4, 1'b1, 32'h1006);
    chk("jalr_wrap_link", 64'(bif.out_link), 64'h0);
    sync();

    // Backpressure: four back-to-back ops against a stalled output
    bif.out_ready = 1'b0;
    base = accepted;
    fork
      begin
        for (int i = 0; i < 4; i++) send_rand();
      end
    join_none
    repeat (4) @(negedge clock);
    chk("bp_accepted", 64'(accepted - base), 64'd2);
    chk("bp_in_ready", 64'(bif.in_ready), 64'd0);
    sync();
    bif.out_ready = 1'b1;
    wait fork;
    drain();
    chk("bp_br_count", 64'(br_count), 64'd8);
    sync();

    // Flush with both stages full and an op on offer
    bif.out_ready = 1'b0;
    send_rand();
    send_rand();
    bif.in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clock);
    chk("flush_in_ready", 64'(bif.in_ready), 64'd0);
    sync();
    flush = 1'b0;
    bif.in_valid = 1'b0;
    @(negedge clock);
    chk("flush_out_valid", 64'(bif.out_valid), 64'd0);
    chk("flush_br_count", 64'(br_count), 64'd8);
    sync();
    bif.out_ready = 1'b1;
    directed("post_flush", 2'd1, 3'b000, 32'h0, 32'h0, 32'h400, 32'h40, 1'b1, 32'h440);
    chk("post_flush_next_pc", 64'(bif.out_next_pc), 64'h440);
    drain();
    chk("post_flush_br_count", 64'(br_count), 64'd9);
    sync();

    // Randomized traffic with backpressure and sporadic flushes
    rnd_bp = 1'b1;
    rnd_fl = 1'b1;
    for (int i = 0; i < 300; i++) send_rand();
    rnd_fl = 1'b0;
    sync();
    flush = 1'b0;
    rnd_bp = 1'b0;
    bif.out_ready = 1'b1;
    drain();
    sync();

    // Asynchronous reset with ops in flight, then counter saturation
    send_rand();
    send_rand();
    #2 reset = 1'b1;
    #1;
    chk("areset_out_valid", 64'(bif.out_valid), 64'd0);
    chk("areset_in_ready", 64'(bif.in_ready), 64'd0);
    chk("areset_counters", 64'({br_count, mispred_count}), 64'd0);
    chk("areset_sat_counters", 64'({br2, mis2}), 64'd0);
    @(posedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    chk("areset_in_ready_after", 64'(bif.in_ready), 64'd1);
    sync();
    for (int i = 0; i < 5; i++) send_rand();
    drain();
    chk("sat_br_count_final", 64'(br2), 64'd3);
    chk("br_count_final", 64'(br_count), 64'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/branch_exec_unit.md
BRANCH_EXEC_UNIT -- requirements
Module: branch_exec_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath width in bits.
REQ-002 Parameter TAG_W, default 5, width of the reservation-station/ROB tag carried with each op.
REQ-003 Parameter CNT_W, default 16, width of each performance counter.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  squash all in-flight ops (mispredict recovery).
REQ-007 in_valid  input  1  op offered.
REQ-008 in_ready  output  1  unit accepts op this cycle.
REQ-009 in_op  input  2  0=BR, 1=JAL, 2=JALR, 3=reserved.
REQ-010 in_func  input  3  branch condition code (funct3).
REQ-011 in_rs1, in_rs2  input  XLEN each  source operands.
REQ-012 in_pc, in_imm  input  XLEN each  instruction PC, sign-extended immediate.
REQ-013 in_pred_taken  input  1; in_pred_target  input  XLEN  front-end prediction.
REQ-014 in_tag  input  TAG_W  op tag.
REQ-015 out_valid  output  1; out_ready  input  1  result handshake.
REQ-016 out_tag  output  TAG_W; out_taken  output  1; out_target  output  XLEN; out_next_pc  output  XLEN; out_link  output  XLEN; out_mispredict  output  1.
REQ-017 br_count, mispred_count  output  CNT_W each  performance counters.

Function
REQ-018 Two registered stages: S1 (operand latch) and S2 (result latch); outputs driven from S2 only.
REQ-019 Op accepted when in_valid && in_ready; in_ready = !S1.valid || S1 advances this cycle; in_ready is 0 while flush=1.
REQ-020 S1 advances to S2 when S1.valid && (!S2.valid || (out_valid && out_ready)); S2 holds while out_valid && !out_ready.
REQ-021 Latency: op accepted in cycle N appears on out_valid in cycle N+2 with no backpressure; sustained throughput one op per cycle.
REQ-022 BR condition from S1 operands: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge; 010/011 -> not taken.
REQ-023 BR and JAL target = pc + imm; JALR target = (rs1 + imm) with bit 0 cleared; all sums modulo 2^XLEN.
REQ-024 JAL and JALR always taken; in_op=3 treated as BR not taken.
REQ-025 out_link = pc + 4 modulo 2^XLEN for all ops.
REQ-026 out_next_pc = out_taken ? out_target : out_link.
REQ-027 out_mispredict = (taken != pred_taken) || (taken && target != pred_target).
REQ-028 flush=1 at a rising edge clears S1.valid and S2.valid; any op offered that cycle is dropped; flushed ops never reach the output or counters.
REQ-029 br_count increments by 1 on each output handshake; mispred_count increments by 1 on each output handshake with out_mispredict=1.
REQ-030 Counters saturate at 2^CNT_W-1; no wrap.
REQ-031 Output data fields hold their values while out_valid && !out_ready (stable under backpressure).

Reset
REQ-032 reset=1 asynchronously clears S1.valid, S2.valid, all data registers, br_count and mispred_count to 0.
REQ-033 While reset=1: out_valid=0, in_ready=0, all data outputs 0; in_ready=1 in the first cycle after deassertion.
REQ-034 reset asserted mid-operation discards all in-flight ops; no output handshake of them occurs.

Verification
REQ-035 BLT signed: rs1=0xFFFFFFFF, rs2=1, func=100, pc=0x100, imm=0x20, pred_taken=0 -> after 2 cycles out_taken=1, target=0x120, next_pc=0x120, mispredict=1, mispred_count=1.
REQ-036 BLTU same operands, func=110, pred_taken=0 -> out_taken=0, next_pc=0x104, link=0x104, mispredict=0.
REQ-037 JALR rs1=0x1003, imm=0x4, pred_taken=1, pred_target=0x1006 -> target=0x1006, taken=1, mispredict=0; pc=0xFFFFFFFC gives link=0x0.
REQ-038 Backpressure: 4 back-to-back ops, out_ready=0 for 3 cycles -> in_ready drops after 2 accepted, S2 data stable, all 4 emerge in order, br_count=4.
REQ-039 flush with S1 and S2 valid and an op offered -> next cycle out_valid=0, no counter change, next accepted op emerges normally.
REQ-040 CNT_W=2, 5 handshakes -> br_count saturates at 3; async reset mid-stream -> counters and out_valid 0 immediately, without waiting for a clock edge.
